// File: rtl/user_flash_pe_ctrl.sv
// Program/erase sequencer for the GW1NR-9 user flash macro: one row erase or one
// 32-bit word program per command, driving the macro pins with datasheet timing.
module user_flash_pe_ctrl #(
  parameter int CLK_FREQ = 27_000_000,
  parameter int T_NVS    = CLK_FREQ / 200_000,
  parameter int T_PGS    = CLK_FREQ / 100_000,
  parameter int T_PROG   = CLK_FREQ / 62_500,
  parameter int T_ERASE  = CLK_FREQ / 1_000 * 6,
  parameter int T_NVH    = CLK_FREQ / 200_000,
  parameter int T_RCV    = CLK_FREQ / 100_000,
  parameter int NUM_ROWS = 304
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_erase,
  input  logic [14:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        inval,
  output logic [8:0]  inval_row,
  output logic        xe,
  output logic        ye,
  output logic        se,
  output logic        prog,
  output logic        erase,
  output logic        nvstr,
  output logic [8:0]  xadr,
  output logic [5:0]  yadr,
  output logic [31:0] din
);

  localparam int CNT_W = ($clog2(T_ERASE + 1) > 18) ? $clog2(T_ERASE + 1) : 18;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_E_NVS = 4'd1;
  localparam logic [3:0] S_E_ERS = 4'd2;
  localparam logic [3:0] S_E_NVH = 4'd3;
  localparam logic [3:0] S_P_NVS = 4'd4;
  localparam logic [3:0] S_P_PGS = 4'd5;
  localparam logic [3:0] S_P_PRG = 4'd6;
  localparam logic [3:0] S_P_NVH = 4'd7;
  localparam logic [3:0] S_RCV   = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;
  logic             r_err;
  logic [8:0]       r_xadr;
  logic [5:0]       r_yadr;
  logic [31:0]      r_din;
  logic [8:0]       r_inval_row;
  logic             r_xe, r_ye, r_prog, r_erase, r_nvstr;
  logic             w_accept, w_bad, w_cnt_zero;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_bad      = 32'(cmd_addr[14:6]) >= 32'(NUM_ROWS);
  assign w_cnt_zero = (r_cnt == '0);

  // Each timed state loads N-1 on entry and exits when the counter reaches zero.
  always_comb begin
    w_next = r_state;
    w_load = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_bad) begin
            w_next = S_DONE;
          end else if (cmd_erase) begin
            w_next = S_E_NVS;
            w_load = CNT_W'(T_NVS - 1);
          end else begin
            w_next = S_P_NVS;
            w_load = CNT_W'(T_NVS - 1);
          end
        end
      end
      S_E_NVS: if (w_cnt_zero) begin w_next = S_E_ERS; w_load = CNT_W'(T_ERASE - 1); end
      S_E_ERS: if (w_cnt_zero) begin w_next = S_E_NVH; w_load = CNT_W'(T_NVH - 1);   end
      S_E_NVH: if (w_cnt_zero) begin w_next = S_RCV;   w_load = CNT_W'(T_RCV - 1);   end
      S_P_NVS: if (w_cnt_zero) begin w_next = S_P_PGS; w_load = CNT_W'(T_PGS - 1);   end
      S_P_PGS: if (w_cnt_zero) begin w_next = S_P_PRG; w_load = CNT_W'(T_PROG - 1);  end
      S_P_PRG: if (w_cnt_zero) begin w_next = S_P_NVH; w_load = CNT_W'(T_NVH - 1);   end
      S_P_NVH: if (w_cnt_zero) begin w_next = S_RCV;   w_load = CNT_W'(T_RCV - 1);   end
      S_RCV:   if (w_cnt_zero) begin w_next = S_DONE; end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Flash pins are registered from the next-state decode so they cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_xadr      <= '0;
      r_yadr      <= '0;
      r_din       <= '0;
      r_inval_row <= '0;
      r_xe        <= 1'b0;
      r_ye        <= 1'b0;
      r_prog      <= 1'b0;
      r_erase     <= 1'b0;
      r_nvstr     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= w_load;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_xe    <= w_next inside {S_E_NVS, S_E_ERS, S_E_NVH, S_P_NVS, S_P_PGS, S_P_PRG, S_P_NVH};
      r_erase <= w_next inside {S_E_NVS, S_E_ERS};
      r_prog  <= w_next inside {S_P_NVS, S_P_PGS, S_P_PRG};
      r_nvstr <= w_next inside {S_E_ERS, S_E_NVH, S_P_PGS, S_P_PRG, S_P_NVH};
      r_ye    <= (w_next == S_P_PRG);
      // A rejected command leaves the address/data pins untouched at zero.
      if (w_accept) begin
        r_err <= w_bad;
        if (!w_bad) begin
          r_xadr <= cmd_addr[14:6];
          r_yadr <= cmd_addr[5:0];
          r_din  <= cmd_data;
        end
      end else if (r_state == S_DONE) begin
        r_err  <= 1'b0;
        r_xadr <= '0;
        r_yadr <= '0;
        r_din  <= '0;
      end
      if ((r_state == S_RCV) && (w_next == S_DONE)) begin
        r_inval_row <= r_xadr;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = done && r_err;
  assign inval     = done && !r_err;
  assign inval_row = r_inval_row;
  assign xe        = r_xe;
  assign ye        = r_ye;
  assign se        = 1'b0;
  assign prog      = r_prog;
  assign erase     = r_erase;
  assign nvstr     = r_nvstr;
  assign xadr      = r_xadr;
  assign yadr      = r_yadr;
  assign din       = r_din;

endmodule
